// File: rtl/min_max_controller_if.sv
// Bundle of the sample-source handshake and the datapath clear/load signals
// seen by the min/max controller.
interface min_max_controller_if #(
  parameter int CNT_W = 16
);
  logic                    start;
  logic [CNT_W-1:0]        count;
  logic                    in_valid;
  logic signed [0:31]      in_data;
  logic                    in_ready;
  logic                    clear;
  logic                    load;
  logic signed [0:31]      data;
  logic                    busy;
  logic                    done;
  logic                    empty;

  modport master (
    output start, count, in_valid, in_data,
    input  in_ready, clear, load, data, busy, done, empty
  );

  modport slave (
    input  start, count, in_valid, in_data,
    output in_ready, clear, load, data, busy, done, empty
  );
endinterface

// File: rtl/min_max_controller.sv
// Sequencer for the min/max datapath: clears it once per run, then forwards
// each accepted sample as a registered load and flags completion.
module min_max_controller #(
  parameter int CNT_W = 16
) (
  input logic                 clock,
  input logic                 reset_n,
  min_max_controller_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    ACCEPT,
    FLUSH,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic signed [0:31] data_q, data_d;
  logic               load_q, load_d;
  logic               empty_q, empty_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      data_q      <= '0;
      load_q      <= 1'b0;
      empty_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
      load_q      <= load_d;
      empty_q     <= empty_d;
    end
  end

  // ACCEPT is only entered with remaining >= 1, so the decrement cannot wrap.
  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    load_d      = 1'b0;
    empty_d     = empty_q;
    case (state_q)
      IDLE: begin
        empty_d = 1'b0;
        if (bus.start) begin
          remaining_d = bus.count;
          state_d     = CLR;
        end
      end
      CLR: begin
        empty_d = (remaining_q == '0);
        state_d = (remaining_q == '0) ? DONE : ACCEPT;
      end
      ACCEPT: begin
        if (bus.in_valid) begin
          data_d      = bus.in_data;
          load_d      = 1'b1;
          remaining_d = remaining_q - 1'b1;
          if (remaining_q == CNT_W'(1)) begin
            state_d = FLUSH;
          end
        end
      end
      FLUSH: begin
        state_d = DONE;
      end
      DONE: begin
        empty_d = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready = (state_q == ACCEPT);
  assign bus.clear    = (state_q == CLR);
  assign bus.busy     = (state_q != IDLE);
  assign bus.done     = (state_q == DONE);
  assign bus.load     = load_q;
  assign bus.data     = data_q;
  assign bus.empty    = empty_q;

endmodule
